// File: rtl/pll_reset_sequencer.sv
// PLL reset supervisor: pulses the PLL reset, qualifies the synchronised lock
// flag over a stability window, releases domain resets in stages, and
// re-sequences on lock loss or soft reset with retry/fault tracking.
module pll_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS         = 2,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 8,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STAGE_DELAY_CYCLES  = 16,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                               refclk,
  input  logic                               reset_n,
  input  logic                               pll_locked,
  input  logic                               soft_reset,
  output logic                               pll_rst,
  output logic [NUM_DOMAINS-1:0]             domain_rst_n,
  output logic                               all_ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [7:0]                         lock_loss_count
);

  localparam int unsigned RW    = $clog2(MAX_RETRIES + 1);
  localparam int unsigned TMAX0 = (PLL_RST_CYCLES > STAGE_DELAY_CYCLES) ?
                                  PLL_RST_CYCLES : STAGE_DELAY_CYCLES;
  localparam int unsigned TMAX1 = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                  LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned TMAX  = (TMAX0 > TMAX1) ? TMAX0 : TMAX1;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam int unsigned IW    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                 state, state_nxt;
  logic [TW-1:0]          timer, timer_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  logic                   rst_nxt, rdy_nxt, flt_nxt;
  logic [NUM_DOMAINS-1:0] dom_nxt;
  logic [RW-1:0]          rty_nxt;
  logic [7:0]             llc_nxt;

  assign locked_s = sync[SYNC_STAGES-1];

  // Synchronise the asynchronous lock flag into the refclk domain
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], pll_locked};
  end

  // State, timers and registered outputs
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_PLL_RESET;
      timer           <= '0;
      idx             <= '0;
      pll_rst         <= 1'b1;
      domain_rst_n    <= '0;
      all_ready       <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      idx             <= idx_nxt;
      pll_rst         <= rst_nxt;
      domain_rst_n    <= dom_nxt;
      all_ready       <= rdy_nxt;
      fault           <= flt_nxt;
      retry_count     <= rty_nxt;
      lock_loss_count <= llc_nxt;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    rst_nxt   = pll_rst;
    dom_nxt   = domain_rst_n;
    rdy_nxt   = all_ready;
    flt_nxt   = fault;
    rty_nxt   = retry_count;
    llc_nxt   = lock_loss_count;

    unique case (state)
      S_PLL_RESET: begin
        if (soft_reset) begin
          timer_nxt = '0;
        end else if (timer == TW'(PLL_RST_CYCLES - 1)) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
          rst_nxt   = 1'b0;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = S_STABLE;
          timer_nxt = '0;
        end else if (timer == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          rty_nxt   = retry_count + RW'(1);
          timer_nxt = '0;
          rst_nxt   = 1'b1;
          if (rty_nxt == RW'(MAX_RETRIES)) begin
            state_nxt = S_FAULT;
            flt_nxt   = 1'b1;
          end else begin
            state_nxt = S_PLL_RESET;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == TW'(LOCK_STABLE_CYCLES - 1)) begin
          state_nxt = S_RELEASE;
          timer_nxt = '0;
          idx_nxt   = '0;
          dom_nxt   = NUM_DOMAINS'(1);
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      S_RELEASE: begin
        if (locked_s) begin
          if (idx == IW'(NUM_DOMAINS - 1)) begin
            state_nxt = S_RUN;
            rdy_nxt   = 1'b1;
            rty_nxt   = '0;
          end else if (timer == TW'(STAGE_DELAY_CYCLES - 1)) begin
            idx_nxt   = idx + IW'(1);
            timer_nxt = '0;
            dom_nxt   = domain_rst_n | (NUM_DOMAINS'(1) << (idx + IW'(1)));
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
      end
      S_RUN: begin
        state_nxt = S_RUN;
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_PLL_RESET;
      end
    endcase

    // Lock loss after qualification overrides the per-state decisions above
    if ((state == S_RELEASE || state == S_RUN) && !locked_s) begin
      state_nxt = S_PLL_RESET;
      timer_nxt = '0;
      rst_nxt   = 1'b1;
      dom_nxt   = '0;
      rdy_nxt   = 1'b0;
      llc_nxt   = (lock_loss_count == 8'hFF) ? 8'hFF : lock_loss_count + 8'd1;
    end

    // Soft reset has the final say, so a coincident lock loss is not counted
    if (soft_reset && state != S_PLL_RESET) begin
      state_nxt = S_PLL_RESET;
      timer_nxt = '0;
      rst_nxt   = 1'b1;
      dom_nxt   = '0;
      rdy_nxt   = 1'b0;
      flt_nxt   = 1'b0;
      rty_nxt   = '0;
      llc_nxt   = lock_loss_count;
    end
  end

endmodule
